// File: rtl/cache_controller.sv
// -----------------------------------------------------------------------------
// cache_controller
//
// Request-side controller for the data_cache array, and the only master of
// that array. It takes single-word CPU reads and writes and splits each
// address into {tag, index}. Hits are resolved against a locally held
// valid-bit vector. Read misses are filled from memory. Writes go
// write-through with allocate.
//
// Ports
//   clk, rst                      clock (rising edge), async active-high reset
//   cpu_req_valid/ready           CPU request handshake
//   cpu_req_wr/addr/wdata         CPU request payload (wr: 1 = write)
//   cpu_rsp_valid                 one-cycle response pulse, no backpressure
//   cpu_rsp_data/hit              read data or echoed write data; hit flag
//   mem_req_valid/ready           memory request handshake
//   mem_req_wr/addr/wdata         memory request payload
//   mem_rsp_valid/data            memory read return
//   cache_enable, rd_wr_sel       array strobe and direction (1 = write)
//   index_sel, write_index        array line select and {valid, tag, data} line
//   cache_read_data, cache_tag    array read data (registered) and tag (comb)
//   hit_count, miss_count         saturating read hit/miss counters
// -----------------------------------------------------------------------------
module cache_controller #(
    parameter int index_count = 256,
    parameter int data        = 11,
    parameter int tag         = 20,
    localparam int IW         = $clog2(index_count),
    localparam int AW         = tag + IW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req_valid,
    output logic                  cpu_req_ready,
    input  logic                  cpu_req_wr,
    input  logic [AW-1:0]         cpu_req_addr,
    input  logic [data-1:0]       cpu_req_wdata,
    output logic                  cpu_rsp_valid,
    output logic [data-1:0]       cpu_rsp_data,
    output logic                  cpu_rsp_hit,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_wr,
    output logic [AW-1:0]         mem_req_addr,
    output logic [data-1:0]       mem_req_wdata,
    input  logic                  mem_rsp_valid,
    input  logic [data-1:0]       mem_rsp_data,
    output logic                  cache_enable,
    output logic                  rd_wr_sel,
    output logic [IW-1:0]         index_sel,
    output logic [tag+data:0]     write_index,
    input  logic [data-1:0]       cache_read_data,
    input  logic [tag-1:0]        cache_tag,
    output logic [15:0]           hit_count,
    output logic [15:0]           miss_count
);

    typedef enum logic [3:0] {
        IDLE, LOOKUP, HIT_RD, MISS_REQ, MISS_WAIT, FILL, WR_CACHE, WR_MEM, RESP
    } state_t;

    state_t                 state;
    logic [AW-1:0]          addr_q;
    logic [data-1:0]        wdata_q;
    logic [data-1:0]        rsp_data_q;
    logic [index_count-1:0] valid_q;
    logic [15:0]            hit_q;
    logic [15:0]            miss_q;

    logic [IW-1:0]          idx;
    logic [tag-1:0]         addr_tag;
    logic                   lookup_hit;

    assign idx        = addr_q[IW-1:0];
    assign addr_tag   = addr_q[AW-1:IW];
    // The array tag follows index_sel combinationally, so this is valid in LOOKUP.
    assign lookup_hit = valid_q[idx] && (cache_tag == addr_tag);

    assign index_sel     = idx;
    assign mem_req_addr  = addr_q;
    assign mem_req_wdata = wdata_q;
    assign cpu_rsp_data  = rsp_data_q;
    assign hit_count     = hit_q;
    assign miss_count    = miss_q;

    // Outputs are registered: each one is set on the edge that enters the
    // state it belongs to, so it is stable for the whole of that state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            rsp_data_q    <= '0;
            // NOTE: valid_q is a flag vector, not a storage array, so it takes
            // the async reset; this is what invalidates every line at once.
            valid_q       <= '0;
            hit_q         <= '0;
            miss_q        <= '0;
            cpu_req_ready <= 1'b0;
            cpu_rsp_valid <= 1'b0;
            cpu_rsp_hit   <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_req_wr    <= 1'b0;
            cache_enable  <= 1'b0;
            rd_wr_sel     <= 1'b0;
            write_index   <= '0;
        end else begin
            // NOTE: non-blocking throughout; the later assignment in a branch
            // overrides these single-cycle defaults.
            cpu_rsp_valid <= 1'b0;
            cache_enable  <= 1'b0;
            rd_wr_sel     <= 1'b0;

            unique case (state)
                IDLE: begin
                    cpu_req_ready <= 1'b1;
                    if (cpu_req_valid && cpu_req_ready) begin
                        cpu_req_ready <= 1'b0;
                        addr_q        <= cpu_req_addr;
                        wdata_q       <= cpu_req_wdata;
                        cache_enable  <= 1'b1;
                        if (cpu_req_wr) begin
                            rd_wr_sel   <= 1'b1;
                            write_index <= {1'b1, cpu_req_addr[AW-1:IW], cpu_req_wdata};
                            state       <= WR_CACHE;
                        end else begin
                            state       <= LOOKUP;
                        end
                    end
                end
                LOOKUP: begin
                    if (lookup_hit) begin
                        if (hit_q != 16'hFFFF) hit_q <= hit_q + 16'd1;
                        state <= HIT_RD;
                    end else begin
                        if (miss_q != 16'hFFFF) miss_q <= miss_q + 16'd1;
                        mem_req_valid <= 1'b1;
                        mem_req_wr    <= 1'b0;
                        state         <= MISS_REQ;
                    end
                end
                HIT_RD: begin
                    // Array read data lands one cycle after the LOOKUP strobe.
                    rsp_data_q    <= cache_read_data;
                    cpu_rsp_hit   <= 1'b1;
                    cpu_rsp_valid <= 1'b1;
                    state         <= RESP;
                end
                MISS_REQ: begin
                    // mem_rsp_valid is deliberately not looked at here.
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= MISS_WAIT;
                    end
                end
                MISS_WAIT: begin
                    if (mem_rsp_valid) begin
                        rsp_data_q   <= mem_rsp_data;
                        cpu_rsp_hit  <= 1'b0;
                        cache_enable <= 1'b1;
                        rd_wr_sel    <= 1'b1;
                        write_index  <= {1'b1, addr_tag, mem_rsp_data};
                        state        <= FILL;
                    end
                end
                FILL: begin
                    valid_q[idx]  <= 1'b1;
                    cpu_rsp_valid <= 1'b1;
                    state         <= RESP;
                end
                WR_CACHE: begin
                    valid_q[idx]  <= 1'b1;
                    mem_req_valid <= 1'b1;
                    mem_req_wr    <= 1'b1;
                    state         <= WR_MEM;
                end
                WR_MEM: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        mem_req_wr    <= 1'b0;
                        rsp_data_q    <= wdata_q;
                        cpu_rsp_hit   <= 1'b0;
                        cpu_rsp_valid <= 1'b1;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    cpu_req_ready <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// -----------------------------------------------------------------------------
// tb_cache_controller
//
// Directed bench for cache_controller. A small behavioural data_cache array
// sits on the array port (registered read data, combinational tag). Memory is
// driven directly by the scenario tasks. Each test task checks its own results
// inline against hand-computed values.
// -----------------------------------------------------------------------------
module tb_cache_controller;

    localparam int IC = 256;
    localparam int D  = 11;
    localparam int T  = 20;
    localparam int IW = 8;
    localparam int AW = T + IW;

    logic            clk = 1'b0;
    logic            rst;
    logic            cpu_req_valid;
    logic            cpu_req_ready;
    logic            cpu_req_wr;
    logic [AW-1:0]   cpu_req_addr;
    logic [D-1:0]    cpu_req_wdata;
    logic            cpu_rsp_valid;
    logic [D-1:0]    cpu_rsp_data;
    logic            cpu_rsp_hit;
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic            mem_req_wr;
    logic [AW-1:0]   mem_req_addr;
    logic [D-1:0]    mem_req_wdata;
    logic            mem_rsp_valid;
    logic [D-1:0]    mem_rsp_data;
    logic            cache_enable;
    logic            rd_wr_sel;
    logic [IW-1:0]   index_sel;
    logic [T+D:0]    write_index;
    logic [D-1:0]    cache_read_data;
    logic [T-1:0]    cache_tag;
    logic [15:0]     hit_count;
    logic [15:0]     miss_count;

    int n_pass  = 0;
    int n_total = 0;

    cache_controller #(.index_count(IC), .data(D), .tag(T)) dut (
        .clk(clk), .rst(rst),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_req_wr(cpu_req_wr), .cpu_req_addr(cpu_req_addr),
        .cpu_req_wdata(cpu_req_wdata),
        .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_data(cpu_rsp_data),
        .cpu_rsp_hit(cpu_rsp_hit),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_wr(mem_req_wr), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .cache_enable(cache_enable), .rd_wr_sel(rd_wr_sel),
        .index_sel(index_sel), .write_index(write_index),
        .cache_read_data(cache_read_data), .cache_tag(cache_tag),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    // Behavioural data_cache array plus activity monitors.
    logic [T-1:0] arr_tag  [IC];
    logic [D-1:0] arr_data [IC];
    int           arr_wr_cnt = 0;
    logic [IW-1:0] last_wr_idx;
    logic [T+D:0]  last_wr_line;
    int           mreq_cnt = 0;
    int           rsp_cnt  = 0;

    assign cache_tag = arr_tag[index_sel];

    always @(posedge clk) begin
        if (cache_enable && rd_wr_sel) begin
            arr_tag[index_sel]  <= write_index[T+D-1:D];
            arr_data[index_sel] <= write_index[D-1:0];
            arr_wr_cnt          <= arr_wr_cnt + 1;
            last_wr_idx         <= index_sel;
            last_wr_line        <= write_index;
        end
        if (cache_enable && !rd_wr_sel) cache_read_data <= arr_data[index_sel];
        if (mem_req_valid && mem_req_ready) mreq_cnt <= mreq_cnt + 1;
        if (cpu_rsp_valid) rsp_cnt <= rsp_cnt + 1;
    end

    // ---------------------------------------------------------------- drivers
    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [D-1:0] wd);
        int n = 0;
        @(negedge clk);
        cpu_req_valid = 1'b1;
        cpu_req_wr    = wr;
        cpu_req_addr  = a;
        cpu_req_wdata = wd;
        while (!cpu_req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_total++;
        if (!cpu_req_ready) $display("FAIL accept_timeout addr=%h ready=%b required 1", a, cpu_req_ready);
        else n_pass++;
        @(posedge clk);
        #1 cpu_req_valid = 1'b0;
    endtask

    // Waits for mem_req_valid, holds ready low for 'stall' cycles while
    // watching the payload, then grants one ready cycle. With 'glitch' set a
    // bogus mem_rsp_valid is driven in the same cycle as ready.
    task automatic serve_req(input int stall, input logic glitch,
                             output logic seen, output logic wr_o,
                             output logic [AW-1:0] a_o, output logic [D-1:0] wd_o,
                             output logic stable);
        int n = 0;
        seen   = 1'b0;
        stable = 1'b1;
        @(negedge clk);
        while (!mem_req_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        seen = mem_req_valid;
        wr_o = mem_req_wr;
        a_o  = mem_req_addr;
        wd_o = mem_req_wdata;
        if (seen) begin
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                if (!mem_req_valid || mem_req_wr !== wr_o || mem_req_addr !== a_o ||
                    mem_req_wdata !== wd_o) stable = 1'b0;
            end
            mem_req_ready = 1'b1;
            if (glitch) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = 11'h111;
            end
            @(posedge clk);
            #1;
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b0;
        end
    endtask

    task automatic give_rsp(input logic [D-1:0] d);
        @(negedge clk);
        @(negedge clk);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = d;
        @(posedge clk);
        #1 mem_rsp_valid = 1'b0;
    endtask

    // Counts cycles (1 = the cycle right after the reference edge) until
    // cpu_rsp_valid; n = 0 on timeout. rdy reports any ready seen meanwhile.
    task automatic wait_rsp(input int max, output int n, output logic rdy);
        n   = 0;
        rdy = 1'b0;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if (cpu_req_ready) rdy = 1'b1;
            if (cpu_rsp_valid) begin
                n = i;
                break;
            end
        end
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        rst = 1'b1;
        cpu_req_valid = 0; cpu_req_wr = 0; cpu_req_addr = '0; cpu_req_wdata = '0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = '0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({cpu_req_ready, cpu_rsp_valid, mem_req_valid, mem_req_wr, cache_enable} !== 5'b0)
            $display("FAIL reset_outputs got=%b required 00000",
                     {cpu_req_ready, cpu_rsp_valid, mem_req_valid, mem_req_wr, cache_enable});
        else n_pass++;
        n_total++;
        if (hit_count !== 16'd0 || miss_count !== 16'd0)
            $display("FAIL reset_counters got=%h/%h required 0000/0000", hit_count, miss_count);
        else n_pass++;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_total++;
        if (cpu_req_ready !== 1'b1) $display("FAIL ready_after_reset got=%b required 1", cpu_req_ready);
        else n_pass++;
    endtask

    task automatic test_cold_read();
        logic seen, wr, stb, rdy; logic [AW-1:0] a; logic [D-1:0] wd; int n, m0;
        m0 = mreq_cnt;
        issue(1'b0, 28'h0000105, '0);
        serve_req(0, 1'b1, seen, wr, a, wd, stb);
        n_total++;
        if (seen !== 1'b1 || wr !== 1'b0 || a !== 28'h0000105)
            $display("FAIL cold_mem_req seen=%b wr=%b addr=%h required 1/0/0000105", seen, wr, a);
        else n_pass++;
        give_rsp(11'h2A5);
        wait_rsp(10, n, rdy);
        n_total++;
        if (n !== 2) $display("FAIL cold_latency got=%0d required 2", n);
        else n_pass++;
        n_total++;
        if (cpu_rsp_data !== 11'h2A5 || cpu_rsp_hit !== 1'b0)
            $display("FAIL cold_rsp data=%h hit=%b required 2a5/0", cpu_rsp_data, cpu_rsp_hit);
        else n_pass++;
        n_total++;
        if (miss_count !== 16'd1 || hit_count !== 16'd0 || mreq_cnt - m0 !== 1)
            $display("FAIL cold_counts miss=%0d hit=%0d memreqs=%0d required 1/0/1",
                     miss_count, hit_count, mreq_cnt - m0);
        else n_pass++;
        n_total++;
        if (last_wr_idx !== 8'h05 || last_wr_line !== {1'b1, 20'h00001, 11'h2A5})
            $display("FAIL cold_fill idx=%h line=%h required 05/%h", last_wr_idx, last_wr_line,
                     {1'b1, 20'h00001, 11'h2A5});
        else n_pass++;
    endtask

    task automatic test_read_hit();
        logic rdy; int n, m0;
        m0 = mreq_cnt;
        issue(1'b0, 28'h0000105, '0);
        wait_rsp(10, n, rdy);
        n_total++;
        if (n !== 3 || rdy !== 1'b0) $display("FAIL hit_latency got=%0d ready_seen=%b required 3/0", n, rdy);
        else n_pass++;
        n_total++;
        if (cpu_rsp_data !== 11'h2A5 || cpu_rsp_hit !== 1'b1)
            $display("FAIL hit_rsp data=%h hit=%b required 2a5/1", cpu_rsp_data, cpu_rsp_hit);
        else n_pass++;
        n_total++;
        if (hit_count !== 16'd1 || miss_count !== 16'd1 || mreq_cnt !== m0)
            $display("FAIL hit_counts hit=%0d miss=%0d memreqs=%0d required 1/1/0",
                     hit_count, miss_count, mreq_cnt - m0);
        else n_pass++;
        // Back to back: controller is ready again the cycle after RESP.
        @(negedge clk);
        n_total++;
        if (cpu_req_ready !== 1'b1) $display("FAIL ready_after_resp got=%b required 1", cpu_req_ready);
        else n_pass++;
    endtask

    task automatic test_conflict();
        logic seen, wr, stb, rdy; logic [AW-1:0] a; logic [D-1:0] wd; int n;
        issue(1'b0, 28'h0000205, '0);
        serve_req(1, 1'b0, seen, wr, a, wd, stb);
        give_rsp(11'h3C3);
        wait_rsp(10, n, rdy);
        n_total++;
        if (seen !== 1'b1 || a !== 28'h0000205 || cpu_rsp_data !== 11'h3C3 || cpu_rsp_hit !== 1'b0)
            $display("FAIL conflict_miss seen=%b addr=%h data=%h hit=%b required 1/0000205/3c3/0",
                     seen, a, cpu_rsp_data, cpu_rsp_hit);
        else n_pass++;
        n_total++;
        if (last_wr_idx !== 8'h05 || last_wr_line !== {1'b1, 20'h00002, 11'h3C3})
            $display("FAIL conflict_fill idx=%h line=%h", last_wr_idx, last_wr_line);
        else n_pass++;
        issue(1'b0, 28'h0000105, '0);
        serve_req(0, 1'b0, seen, wr, a, wd, stb);
        give_rsp(11'h2A5);
        wait_rsp(10, n, rdy);
        n_total++;
        if (seen !== 1'b1 || cpu_rsp_hit !== 1'b0 || miss_count !== 16'd3 || hit_count !== 16'd1)
            $display("FAIL conflict_reread seen=%b hit=%b miss=%0d hits=%0d required 1/0/3/1",
                     seen, cpu_rsp_hit, miss_count, hit_count);
        else n_pass++;
    endtask

    task automatic test_write();
        logic seen, wr, stb, rdy; logic [AW-1:0] a; logic [D-1:0] wd; int n;
        issue(1'b1, 28'h0ABCD10, 11'h7FF);
        serve_req(5, 1'b0, seen, wr, a, wd, stb);
        n_total++;
        if (seen !== 1'b1 || wr !== 1'b1 || a !== 28'h0ABCD10 || wd !== 11'h7FF || stb !== 1'b1)
            $display("FAIL write_mem_req seen=%b wr=%b addr=%h wdata=%h stable=%b required 1/1/0abcd10/7ff/1",
                     seen, wr, a, wd, stb);
        else n_pass++;
        n_total++;
        if (last_wr_idx !== 8'h10 || last_wr_line !== {1'b1, 20'h0ABCD, 11'h7FF})
            $display("FAIL write_array idx=%h line=%h", last_wr_idx, last_wr_line);
        else n_pass++;
        wait_rsp(10, n, rdy);
        n_total++;
        if (n !== 1 || cpu_rsp_data !== 11'h7FF || cpu_rsp_hit !== 1'b0)
            $display("FAIL write_rsp lat=%0d data=%h hit=%b required 1/7ff/0", n, cpu_rsp_data, cpu_rsp_hit);
        else n_pass++;
        n_total++;
        if (hit_count !== 16'd1 || miss_count !== 16'd3)
            $display("FAIL write_counts hit=%0d miss=%0d required 1/3", hit_count, miss_count);
        else n_pass++;
        issue(1'b0, 28'h0ABCD10, '0);
        wait_rsp(10, n, rdy);
        n_total++;
        if (n !== 3 || cpu_rsp_data !== 11'h7FF || cpu_rsp_hit !== 1'b1 || hit_count !== 16'd2)
            $display("FAIL write_then_read lat=%0d data=%h hit=%b hits=%0d required 3/7ff/1/2",
                     n, cpu_rsp_data, cpu_rsp_hit, hit_count);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic seen, wr, stb, rdy; logic [AW-1:0] a; logic [D-1:0] wd; int n, r0;
        issue(1'b0, 28'h0ABCE10, '0);
        serve_req(0, 1'b0, seen, wr, a, wd, stb);
        r0 = rsp_cnt;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_total++;
        if ({cpu_req_ready, mem_req_valid, cache_enable, hit_count, miss_count} !== 35'b0)
            $display("FAIL midreset_outputs ready=%b mreq=%b en=%b hit=%0d miss=%0d required all 0",
                     cpu_req_ready, mem_req_valid, cache_enable, hit_count, miss_count);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 11'h4D4;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        repeat (6) @(negedge clk);
        n_total++;
        if (rsp_cnt !== r0) $display("FAIL midreset_no_rsp got=%0d responses required 0", rsp_cnt - r0);
        else n_pass++;
        // Previously hitting address must miss now that valid bits are cleared.
        issue(1'b0, 28'h0ABCD10, '0);
        serve_req(0, 1'b0, seen, wr, a, wd, stb);
        give_rsp(11'h055);
        wait_rsp(10, n, rdy);
        n_total++;
        if (seen !== 1'b1 || n !== 2 || cpu_rsp_hit !== 1'b0 || cpu_rsp_data !== 11'h055 ||
            miss_count !== 16'd1 || hit_count !== 16'd0)
            $display("FAIL midreset_remiss seen=%b lat=%0d hit=%b data=%h miss=%0d hits=%0d required 1/2/0/055/1/0",
                     seen, n, cpu_rsp_hit, cpu_rsp_data, miss_count, hit_count);
        else n_pass++;
    endtask

    task automatic test_saturation();
        logic rdy; int n;
        @(negedge clk);
        force dut.hit_q = 16'hFFFF;
        @(negedge clk);
        release dut.hit_q;
        issue(1'b0, 28'h0ABCD10, '0);
        wait_rsp(10, n, rdy);
        n_total++;
        if (n !== 3 || cpu_rsp_hit !== 1'b1 || cpu_rsp_data !== 11'h055)
            $display("FAIL sat_rsp lat=%0d hit=%b data=%h required 3/1/055", n, cpu_rsp_hit, cpu_rsp_data);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (hit_count !== 16'hFFFF || miss_count !== 16'd1)
            $display("FAIL sat_counter hit=%h miss=%0d required ffff/1", hit_count, miss_count);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_cold_read();
        test_read_hit();
        test_conflict();
        test_write();
        test_reset_mid();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $finish;
    end

endmodule
